// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage RV64 pipeline: forwarding,
// load-use stalls, branch flushes, memory-wait freeze with timeout, stall counter.
module pipeline_ctrl #(
    parameter int REG_ADDR_W     = 5,
    parameter int INIT_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 32
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr_dec,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr_dec,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr_exec,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr_exec,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_exec,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_mem,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_wb,
    input  logic                  i_reg_we_mem,
    input  logic                  i_reg_we_wb,
    input  logic                  i_load_exec,
    input  logic                  i_pc_src_exec,
    input  logic                  i_mem_req_mem,
    input  logic                  i_mem_ready,
    output logic                  o_stall_fetch,
    output logic                  o_stall_dec,
    output logic                  o_flush_dec,
    output logic                  o_flush_exec,
    output logic                  o_freeze,
    output logic [1:0]            o_forward_rs1,
    output logic [1:0]            o_forward_rs2,
    output logic                  o_bus_error,
    output logic [CNT_W-1:0]      o_stall_count
);

    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_MEM_WAIT, S_HALT} state_t;

    state_t            state, state_nxt;
    logic [INIT_W-1:0] init_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lu, mw, init_done, wait_expired;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd_mem,
        input logic                  we_mem,
        input logic [REG_ADDR_W-1:0] rd_wb,
        input logic                  we_wb
    );
        // The mem-stage result is younger, so it wins over wb.
        if (we_mem && (rd_mem != '0) && (rd_mem == rs))
            return 2'b10;
        else if (we_wb && (rd_wb != '0) && (rd_wb == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign o_forward_rs1 = fwd_sel(i_rs1_addr_exec, i_rd_addr_mem, i_reg_we_mem,
                                   i_rd_addr_wb, i_reg_we_wb);
    assign o_forward_rs2 = fwd_sel(i_rs2_addr_exec, i_rd_addr_mem, i_reg_we_mem,
                                   i_rd_addr_wb, i_reg_we_wb);

    assign lu = i_load_exec && (i_rd_addr_exec != '0) &&
                ((i_rd_addr_exec == i_rs1_addr_dec) || (i_rd_addr_exec == i_rs2_addr_dec));
    assign mw = i_mem_req_mem && !i_mem_ready;

    assign init_done    = (init_cnt == INIT_W'(INIT_CYCLES - 1));
    assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst)
            state <= S_INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_INIT:     if (init_done) state_nxt = S_RUN;
            S_RUN:      if (mw) state_nxt = S_MEM_WAIT;
            S_MEM_WAIT: begin
                if (i_mem_ready)       state_nxt = S_RUN;
                else if (wait_expired) state_nxt = S_HALT;
            end
            S_HALT:     state_nxt = S_HALT;
            default:    state_nxt = S_INIT;
        endcase
    end

    // Wrong-path decode is flushed rather than stalled when a branch resolves.
    always_comb begin
        o_stall_fetch = 1'b0;
        o_stall_dec   = 1'b0;
        o_flush_dec   = 1'b0;
        o_flush_exec  = 1'b0;
        o_freeze      = 1'b0;
        unique case (state)
            S_INIT: begin
                o_stall_fetch = 1'b1;
                o_flush_dec   = 1'b1;
                o_flush_exec  = 1'b1;
            end
            S_RUN, S_MEM_WAIT: begin
                if ((state == S_RUN) ? mw : !i_mem_ready) begin
                    o_freeze      = 1'b1;
                    o_stall_fetch = 1'b1;
                    o_stall_dec   = 1'b1;
                end else begin
                    o_stall_fetch = lu && !i_pc_src_exec;
                    o_stall_dec   = lu && !i_pc_src_exec;
                    o_flush_dec   = i_pc_src_exec;
                    o_flush_exec  = lu || i_pc_src_exec;
                end
            end
            S_HALT: begin
                o_freeze      = 1'b1;
                o_stall_fetch = 1'b1;
                o_stall_dec   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            init_cnt      <= '0;
            wait_cnt      <= '0;
            o_bus_error   <= 1'b0;
            o_stall_count <= '0;
        end else begin
            if (state == S_INIT && !init_done)
                init_cnt <= init_cnt + INIT_W'(1);
            // The RUN cycle that first sees the wait is wait cycle number one.
            if (state == S_RUN && mw)
                wait_cnt <= WAIT_W'(1);
            else if (state == S_MEM_WAIT && !i_mem_ready && !wait_expired)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (state == S_MEM_WAIT && !i_mem_ready && wait_expired)
                o_bus_error <= 1'b1;
            if ((state == S_RUN || state == S_MEM_WAIT) && o_stall_fetch)
                o_stall_count <= o_stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a behavioural model queues the expected
// controls for each driven cycle, and they are compared mid-cycle.
module tb_pipeline_ctrl;

    localparam int AW    = 5;
    localparam int INITC = 4;
    localparam int TOUT  = 8;
    localparam int CW    = 4;

    localparam int M_INIT = 0, M_RUN = 1, M_WAIT = 2, M_HALT = 3;

    typedef struct packed {
        logic [4:0]    ctrl;   // {stall_fetch, stall_dec, flush_dec, flush_exec, freeze}
        logic [1:0]    f1;
        logic [1:0]    f2;
        logic          err;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          i_clk = 1'b0;
    logic          i_arst = 1'b1;
    logic [AW-1:0] i_rs1_addr_dec, i_rs2_addr_dec, i_rs1_addr_exec, i_rs2_addr_exec;
    logic [AW-1:0] i_rd_addr_exec, i_rd_addr_mem, i_rd_addr_wb;
    logic          i_reg_we_mem, i_reg_we_wb, i_load_exec, i_pc_src_exec;
    logic          i_mem_req_mem, i_mem_ready;
    logic          o_stall_fetch, o_stall_dec, o_flush_dec, o_flush_exec, o_freeze;
    logic [1:0]    o_forward_rs1, o_forward_rs2;
    logic          o_bus_error;
    logic [CW-1:0] o_stall_count;

    pipeline_ctrl #(
        .REG_ADDR_W(AW), .INIT_CYCLES(INITC), .TIMEOUT_CYCLES(TOUT), .CNT_W(CW)
    ) dut (
        .i_clk(i_clk), .i_arst(i_arst),
        .i_rs1_addr_dec(i_rs1_addr_dec), .i_rs2_addr_dec(i_rs2_addr_dec),
        .i_rs1_addr_exec(i_rs1_addr_exec), .i_rs2_addr_exec(i_rs2_addr_exec),
        .i_rd_addr_exec(i_rd_addr_exec), .i_rd_addr_mem(i_rd_addr_mem),
        .i_rd_addr_wb(i_rd_addr_wb), .i_reg_we_mem(i_reg_we_mem),
        .i_reg_we_wb(i_reg_we_wb), .i_load_exec(i_load_exec),
        .i_pc_src_exec(i_pc_src_exec), .i_mem_req_mem(i_mem_req_mem),
        .i_mem_ready(i_mem_ready), .o_stall_fetch(o_stall_fetch),
        .o_stall_dec(o_stall_dec), .o_flush_dec(o_flush_dec),
        .o_flush_exec(o_flush_exec), .o_freeze(o_freeze),
        .o_forward_rs1(o_forward_rs1), .o_forward_rs2(o_forward_rs2),
        .o_bus_error(o_bus_error), .o_stall_count(o_stall_count)
    );

    always #5 i_clk = ~i_clk;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    int      m_state = M_INIT;
    int      m_init  = 0;
    int      m_wait  = 0;
    logic    m_err   = 1'b0;
    int      m_cnt   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [AW-1:0] rs);
        if (i_reg_we_mem && i_rd_addr_mem != 0 && i_rd_addr_mem == rs) return 2'd2;
        if (i_reg_we_wb && i_rd_addr_wb != 0 && i_rd_addr_wb == rs) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic m_lu();
        return i_load_exec && i_rd_addr_exec != 0 &&
               (i_rd_addr_exec == i_rs1_addr_dec || i_rd_addr_exec == i_rs2_addr_dec);
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        logic sf, sd, fd, fe, fz, hold;
        sf = 0; sd = 0; fd = 0; fe = 0; fz = 0;
        hold = (m_state == M_HALT) ||
               (m_state == M_RUN && i_mem_req_mem && !i_mem_ready) ||
               (m_state == M_WAIT && !i_mem_ready);
        if (i_arst || m_state == M_INIT) begin
            sf = 1; fd = 1; fe = 1;
        end else if (hold) begin
            sf = 1; sd = 1; fz = 1;
        end else begin
            sf = m_lu() && !i_pc_src_exec;
            sd = sf;
            fd = i_pc_src_exec;
            fe = m_lu() || i_pc_src_exec;
        end
        e.ctrl = {sf, sd, fd, fe, fz};
        e.f1   = m_fwd(i_rs1_addr_exec);
        e.f2   = m_fwd(i_rs2_addr_exec);
        e.err  = m_err;
        e.cnt  = CW'(m_cnt);
        return e;
    endfunction

    task automatic model_reset();
        m_state = M_INIT; m_init = 0; m_wait = 0; m_err = 0; m_cnt = 0;
    endtask

    // Expected values are queued at drive time, compared on the falling edge.
    task automatic drive_check(input string tag);
        exp_t e, g;
        sb_q.push_back(model_exp());
        @(negedge i_clk);
        e = sb_q.pop_front();
        g.ctrl = {o_stall_fetch, o_stall_dec, o_flush_dec, o_flush_exec, o_freeze};
        check_eq({tag, "_ctrl"}, 32'(g.ctrl), 32'(e.ctrl));
        check_eq({tag, "_fwd1"}, 32'(o_forward_rs1), 32'(e.f1));
        check_eq({tag, "_fwd2"}, 32'(o_forward_rs2), 32'(e.f2));
        check_eq({tag, "_err"}, 32'(o_bus_error), 32'(e.err));
        check_eq({tag, "_cnt"}, 32'(o_stall_count), 32'(e.cnt));
    endtask

    task automatic tick();
        logic sf;
        exp_t e;
        e  = model_exp();
        sf = e.ctrl[4];
        @(posedge i_clk);
        if (i_arst) model_reset();
        else begin
            if ((m_state == M_RUN || m_state == M_WAIT) && sf) m_cnt = (m_cnt + 1) % (1 << CW);
            case (m_state)
                M_INIT: if (m_init == INITC - 1) m_state = M_RUN; else m_init++;
                M_RUN:  if (i_mem_req_mem && !i_mem_ready) begin m_state = M_WAIT; m_wait = 1; end
                M_WAIT: begin
                    if (i_mem_ready) m_state = M_RUN;
                    else if (m_wait == TOUT - 1) begin m_state = M_HALT; m_err = 1; end
                    else m_wait++;
                end
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic cycle(input string tag);
        drive_check(tag);
        tick();
    endtask

    task automatic clear_in();
        i_rs1_addr_dec = 0; i_rs2_addr_dec = 0; i_rs1_addr_exec = 0; i_rs2_addr_exec = 0;
        i_rd_addr_exec = 0; i_rd_addr_mem = 0; i_rd_addr_wb = 0;
        i_reg_we_mem = 0; i_reg_we_wb = 0; i_load_exec = 0; i_pc_src_exec = 0;
        i_mem_req_mem = 0; i_mem_ready = 0;
    endtask

    task automatic do_reset();
        clear_in();
        i_arst = 1'b1;
        model_reset();
        #1;
        check_eq("arst_err", 32'(o_bus_error), 32'd0);
        check_eq("arst_cnt", 32'(o_stall_count), 32'd0);
        cycle("rst");
        i_arst = 1'b0;
        for (int i = 0; i < INITC; i++) cycle("init");
    endtask

    initial begin
        clear_in();
        #2;
        do_reset();
        cycle("run_idle");
        check_eq("idle_ctrl", 32'({o_stall_fetch, o_flush_dec, o_flush_exec}), 32'd0);

        // forwarding priority
        i_rd_addr_mem = 5; i_rd_addr_wb = 5; i_rs1_addr_exec = 5;
        i_reg_we_mem = 1; i_reg_we_wb = 1; i_rs2_addr_exec = 6;
        drive_check("fwd_mem");
        check_eq("fwd_mem_const", 32'(o_forward_rs1), 32'd2);
        tick();
        i_rd_addr_mem = 0;
        drive_check("fwd_wb");
        check_eq("fwd_wb_const", 32'(o_forward_rs1), 32'd1);
        tick();
        i_rs1_addr_exec = 0; i_rd_addr_wb = 0;
        cycle("fwd_none");
        i_rd_addr_mem = 6; i_rd_addr_wb = 6; i_rs2_addr_exec = 6;
        cycle("fwd_rs2");
        clear_in();

        // load-use, then load-use with branch
        do_reset();
        i_load_exec = 1; i_rd_addr_exec = 7; i_rs2_addr_dec = 7;
        drive_check("lu");
        check_eq("lu_stall", 32'({o_stall_fetch, o_stall_dec, o_flush_exec}), 32'h7);
        tick();
        clear_in();
        cycle("lu_after");
        check_eq("lu_count", 32'(o_stall_count), 32'd1);
        i_load_exec = 1; i_rd_addr_exec = 7; i_rs1_addr_dec = 7; i_pc_src_exec = 1;
        drive_check("lu_br");
        check_eq("lu_br_ctrl", 32'({o_stall_fetch, o_stall_dec, o_flush_dec, o_flush_exec}), 32'h3);
        tick();
        clear_in();

        // memory wait with pending branch
        do_reset();
        i_mem_req_mem = 1; i_mem_ready = 0; i_pc_src_exec = 1;
        for (int i = 0; i < 3; i++) cycle("mw");
        i_mem_ready = 1;
        drive_check("mw_rel");
        check_eq("mw_rel_ctrl", 32'({o_freeze, o_flush_dec, o_flush_exec}), 32'h3);
        tick();
        clear_in();
        cycle("mw_after");
        check_eq("mw_count", 32'(o_stall_count), 32'd3);

        // timeout into HALT
        do_reset();
        i_mem_req_mem = 1; i_mem_ready = 0;
        for (int i = 0; i < TOUT; i++) cycle("to_wait");
        i_mem_ready = 1;
        for (int i = 0; i < 3; i++) cycle("halt");
        check_eq("halt_err", 32'(o_bus_error), 32'd1);
        check_eq("halt_cnt", 32'(o_stall_count), 32'(TOUT % (1 << CW)));
        check_eq("halt_freeze", 32'(o_freeze), 32'd1);
        do_reset();

        // counter wrap
        i_load_exec = 1; i_rd_addr_exec = 3; i_rs1_addr_dec = 3;
        for (int i = 0; i < 17; i++) cycle("wrap");
        clear_in();
        cycle("wrap_after");
        check_eq("wrap_cnt", 32'(o_stall_count), 32'd1);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            i_rs1_addr_dec = AW'($urandom_range(0, 3)); i_rs2_addr_dec = AW'($urandom_range(0, 3));
            i_rs1_addr_exec = AW'($urandom_range(0, 3)); i_rs2_addr_exec = AW'($urandom_range(0, 3));
            i_rd_addr_exec = AW'($urandom_range(0, 3)); i_rd_addr_mem = AW'($urandom_range(0, 3));
            i_rd_addr_wb = AW'($urandom_range(0, 3));
            i_reg_we_mem = 1'($urandom); i_reg_we_wb = 1'($urandom);
            i_load_exec = 1'($urandom); i_pc_src_exec = ($urandom_range(0, 3) == 0);
            i_mem_req_mem = 1'($urandom); i_mem_ready = ($urandom_range(0, 2) != 0);
            cycle("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
